// File: rtl/fetch_pc_controller_if.sv
// Decode-side handshake bundle for the fetch stage.
//   out_d_valid       fetch -> decode  output register holds an instruction
//   in_d_ready        decode -> fetch  decode accepts this cycle
//   out_d_insnbits    fetch -> decode  instruction word
//   out_d_pc          fetch -> decode  PC of that instruction
//   out_d_pred_taken  fetch -> decode  instruction was predicted taken
interface fetch_pc_controller_if;
    logic        out_d_valid;
    logic        in_d_ready;
    logic [31:0] out_d_insnbits;
    logic [63:0] out_d_pc;
    logic        out_d_pred_taken;

    modport master (
        output out_d_valid,
        output out_d_insnbits,
        output out_d_pc,
        output out_d_pred_taken,
        input  in_d_ready
    );

    modport slave (
        input  out_d_valid,
        input  out_d_insnbits,
        input  out_d_pc,
        input  out_d_pred_taken,
        output in_d_ready
    );
endinterface

// File: rtl/fetch_pc_controller.sv
// Fetch-stage sequencer. Owns the fetch PC, drives the imem address, applies
// static prediction (branches taken, everything else PC+4), stalls on RET
// until execute redirects, and presents instructions to decode through a
// one-entry output register with a valid/ready handshake.
// Ports:
//   in_clk, in_rst_n        clock, asynchronous active-low reset
//   in_start, in_entry_pc   start pulse and program entry address (IDLE only)
//   out_imem_addr           imem read address (= PC)
//   in_imem_insnbits        instruction word at out_imem_addr
//   in_is_br, in_is_ret     combinational decode of in_imem_insnbits
//   in_br_imm               sign-extended branch byte offset
//   in_x_redirect_valid/pc  execute-stage PC correction
//   dec                     decode handshake (master side)
//   out_state               IDLE=0 RUN=1 WAIT_RET=2 HALT=3
//   out_fault               sticky misaligned / out-of-page PC flag
//   out_fetch_count         instructions loaded into the output register
module fetch_pc_controller #(
    parameter int PAGESIZE = 4096,
    parameter int CNT_W    = 32
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_start,
    input  logic [63:0]                   in_entry_pc,
    output logic [63:0]                   out_imem_addr,
    input  logic [31:0]                   in_imem_insnbits,
    input  logic                          in_is_br,
    input  logic                          in_is_ret,
    input  logic [63:0]                   in_br_imm,
    input  logic                          in_x_redirect_valid,
    input  logic [63:0]                   in_x_redirect_pc,
    fetch_pc_controller_if.master         dec,
    output logic [1:0]                    out_state,
    output logic                          out_fault,
    output logic [CNT_W-1:0]              out_fetch_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_RET = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [31:0]        insn_q, insn_d;
    logic [63:0]        dpc_q, dpc_d;
    logic               pred_q, pred_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic slot_free;
    logic handshake;
    logic pc_bad;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            insn_q  <= '0;
            dpc_q   <= '0;
            pred_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            insn_q  <= insn_d;
            dpc_q   <= dpc_d;
            pred_q  <= pred_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        insn_d    = insn_q;
        dpc_d     = dpc_q;
        pred_d    = pred_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        slot_free = !valid_q || dec.in_d_ready;
        handshake = valid_q && dec.in_d_ready;
        pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q >= 64'(PAGESIZE));

        // Redirect outranks everything outside IDLE; decided first so a
        // same-cycle fetch never loads the output register or bumps the count.
        if (state_q != IDLE && in_x_redirect_valid) begin
            pc_d    = in_x_redirect_pc;
            state_d = RUN;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_start) begin
                        pc_d    = in_entry_pc;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (slot_free) begin
                        if (pc_bad) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                            valid_d = 1'b0;
                        end else if (in_imem_insnbits == 32'h0) begin
                            state_d = HALT;
                            valid_d = 1'b0;
                        end else begin
                            valid_d = 1'b1;
                            insn_d  = in_imem_insnbits;
                            dpc_d   = pc_q;
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (in_is_br) begin
                                pc_d   = pc_q + in_br_imm;
                                pred_d = 1'b1;
                            end else if (in_is_ret) begin
                                pred_d  = 1'b0;
                                state_d = WAIT_RET;
                            end else begin
                                pc_d   = pc_q + 64'd4;
                                pred_d = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    // WAIT_RET / HALT: no fetch, just drain the held insn.
                    if (handshake) begin
                        valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_imem_addr        = pc_q;
    assign dec.out_d_valid      = valid_q;
    assign dec.out_d_insnbits   = insn_q;
    assign dec.out_d_pc         = dpc_q;
    assign dec.out_d_pred_taken = pred_q;
    assign out_state            = state_q;
    assign out_fault            = fault_q;
    assign out_fetch_count      = cnt_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Self-checking bench for fetch_pc_controller: a 4 KiB imem model with an
// AArch64-style decode, a scoreboard of expected decode-side transfers, and
// one task per scenario.
module tb_fetch_pc_controller;

    localparam logic [31:0] ADD = 32'h8B020020;
    localparam logic [31:0] RET = 32'hD65F03C0;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] entry_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_insn;
    logic        is_br;
    logic        is_ret;
    logic [63:0] br_imm;
    logic        redir;
    logic [63:0] redir_pc;
    logic [1:0]  state;
    logic        fault;
    logic [31:0] count;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
        logic        pred;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    fetch_pc_controller_if dec();

    fetch_pc_controller #(.PAGESIZE(4096), .CNT_W(32)) dut (
        .in_clk              (clk),
        .in_rst_n            (rst_n),
        .in_start            (start),
        .in_entry_pc         (entry_pc),
        .out_imem_addr       (imem_addr),
        .in_imem_insnbits    (imem_insn),
        .in_is_br            (is_br),
        .in_is_ret           (is_ret),
        .in_br_imm           (br_imm),
        .in_x_redirect_valid (redir),
        .in_x_redirect_pc    (redir_pc),
        .dec                 (dec),
        .out_state           (state),
        .out_fault           (fault),
        .out_fetch_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem and decode model
    assign imem_insn = (imem_addr < 64'd4096) ? mem[imem_addr[11:2]] : 32'h0;
    assign is_br  = (imem_insn[31:26] == 6'b000101) || (imem_insn[31:26] == 6'b100101) ||
                    (imem_insn[31:24] == 8'h54);
    assign is_ret = (imem_insn == RET);
    always_comb begin
        if (imem_insn[31:24] == 8'h54)
            br_imm = {{43{imem_insn[23]}}, imem_insn[23:5], 2'b00};
        else
            br_imm = {{36{imem_insn[25]}}, imem_insn[25:0], 2'b00};
    end

    // scoreboard: every completed handshake must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && dec.out_d_valid && dec.in_d_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h insn=%h, required no transfer",
                         dec.out_d_pc, dec.out_d_insnbits);
            end else begin
                e = sb.pop_front();
                if (dec.out_d_pc !== e.pc || dec.out_d_insnbits !== e.insn ||
                    dec.out_d_pred_taken !== e.pred) begin
                    bad++;
                    $display("FAIL sb_insn: got pc=%h insn=%h pred=%b, required pc=%h insn=%h pred=%b",
                             dec.out_d_pc, dec.out_d_insnbits, dec.out_d_pred_taken,
                             e.pc, e.insn, e.pred);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] insn, input logic pred);
        exp_t x;
        x.pc = pc; x.insn = insn; x.pred = pred;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redir = 1'b0;
        entry_pc = '0;
        redir_pc = '0;
        dec.in_d_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redir = 1'b0;
        dec.in_d_ready = 1'b1;
        #3;
        total++;
        if (state !== 2'd0 || dec.out_d_valid !== 1'b0 || fault !== 1'b0 ||
            count !== 32'd0 || imem_addr !== 64'd0 || dec.out_d_pc !== 64'd0) begin
            bad++;
            $display("FAIL reset_values: got state=%0d valid=%b fault=%b count=%0d addr=%h dpc=%h, required all 0",
                     state, dec.out_d_valid, fault, count, imem_addr, dec.out_d_pc);
        end
        do_reset();
    endtask

    task automatic test_idle();
        do_reset();
        redir = 1'b1; redir_pc = 64'h40;
        tick();
        total++;
        if (state !== 2'd0 || imem_addr !== 64'd0) begin
            bad++;
            $display("FAIL idle_redirect: got state=%0d addr=%h, required 0/0", state, imem_addr);
        end
        start = 1'b1; entry_pc = 64'h100;
        tick();
        start = 1'b0; redir = 1'b0;
        total++;
        if (state !== 2'd1 || imem_addr !== 64'h100) begin
            bad++;
            $display("FAIL idle_start_wins: got state=%0d addr=%h, required 1/100", state, imem_addr);
        end
        // empty imem: next fetch halts; a start outside IDLE must be ignored
        start = 1'b1; entry_pc = 64'h500;
        tick();
        start = 1'b0;
        total++;
        if (state !== 2'd3 || imem_addr !== 64'h100 || fault !== 1'b0 || dec.out_d_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_outside_idle: got state=%0d addr=%h fault=%b valid=%b, required 3/100/0/0",
                     state, imem_addr, fault, dec.out_d_valid);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem[64+i] = ADD;
            push(64'h100 + 64'(4*i), ADD, 1'b0);
        end
        entry_pc = 64'h100; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (dec.out_d_valid !== 1'b1 || dec.out_d_pc !== 64'h100 + 64'(4*i)) begin
                bad++;
                $display("FAIL seq_pc[%0d]: got valid=%b pc=%h, required 1/%h",
                         i, dec.out_d_valid, dec.out_d_pc, 64'h100 + 64'(4*i));
            end
        end
        tick();
        total++;
        if (state !== 2'd3 || dec.out_d_valid !== 1'b0 || count !== 32'd4 || fault !== 1'b0) begin
            bad++;
            $display("FAIL seq_end: got state=%0d valid=%b count=%0d fault=%b, required 3/0/4/0",
                     state, dec.out_d_valid, count, fault);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL seq_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_branch();
        // B +0x40, then B.cond +8, straight-line ADDs, zero terminates
        do_reset();
        mem[64] = 32'h14000010;
        mem[80] = ADD;
        mem[81] = 32'h54000040;
        mem[83] = ADD;
        push(64'h100, 32'h14000010, 1'b1);
        push(64'h140, ADD, 1'b0);
        push(64'h144, 32'h54000040, 1'b1);
        push(64'h14C, ADD, 1'b0);
        entry_pc = 64'h100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (dec.out_d_pred_taken !== 1'b1 || imem_addr !== 64'h140) begin
            bad++;
            $display("FAIL br_fwd: got pred=%b addr=%h, required 1/140", dec.out_d_pred_taken, imem_addr);
        end
        tick();
        total++;
        if (dec.out_d_pc !== 64'h140 || dec.out_d_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL br_target: got pc=%h pred=%b, required 140/0", dec.out_d_pc, dec.out_d_pred_taken);
        end
        tick(); tick(); tick();
        total++;
        if (state !== 2'd3 || count !== 32'd4 || sb.size() != 0) begin
            bad++;
            $display("FAIL br_end: got state=%0d count=%0d pending=%0d, required 3/4/0",
                     state, count, sb.size());
        end
        // B -8
        do_reset();
        mem[64] = 32'h17FFFFFE;
        mem[62] = ADD;
        push(64'h100, 32'h17FFFFFE, 1'b1);
        push(64'hF8, ADD, 1'b0);
        entry_pc = 64'h100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (imem_addr !== 64'hF8) begin
            bad++;
            $display("FAIL br_back: got addr=%h, required f8", imem_addr);
        end
        tick();
        total++;
        if (dec.out_d_pc !== 64'hF8) begin
            bad++;
            $display("FAIL br_back_pc: got pc=%h, required f8", dec.out_d_pc);
        end
        tick();
        total++;
        if (state !== 2'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL br_back_end: got state=%0d pending=%0d, required 3/0", state, sb.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem[64+i] = ADD + 32'(i);
            push(64'h100 + 64'(4*i), ADD + 32'(i), 1'b0);
        end
        entry_pc = 64'h100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dec.in_d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dec.out_d_valid !== 1'b1 || dec.out_d_pc !== 64'h100 || dec.out_d_insnbits !== ADD ||
                imem_addr !== 64'h104 || count !== 32'd1) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b pc=%h insn=%h addr=%h count=%0d, required 1/100/%h/104/1",
                         i, dec.out_d_valid, dec.out_d_pc, dec.out_d_insnbits, imem_addr, count, ADD);
            end
        end
        dec.in_d_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (state !== 2'd3 || count !== 32'd6 || sb.size() != 0) begin
            bad++;
            $display("FAIL stall_end: got state=%0d count=%0d pending=%0d, required 3/6/0",
                     state, count, sb.size());
        end
    endtask

    task automatic test_ret();
        do_reset();
        mem[128] = RET;
        mem[129] = ADD;
        mem[192] = ADD;
        push(64'h200, RET, 1'b0);
        entry_pc = 64'h200; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (state !== 2'd2 || dec.out_d_valid !== 1'b1 || dec.out_d_pc !== 64'h200) begin
            bad++;
            $display("FAIL ret_wait: got state=%0d valid=%b pc=%h, required 2/1/200",
                     state, dec.out_d_valid, dec.out_d_pc);
        end
        tick(); tick();
        total++;
        if (state !== 2'd2 || dec.out_d_valid !== 1'b0 || imem_addr !== 64'h200 || count !== 32'd1) begin
            bad++;
            $display("FAIL ret_nofetch: got state=%0d valid=%b addr=%h count=%0d, required 2/0/200/1",
                     state, dec.out_d_valid, imem_addr, count);
        end
        redir = 1'b1; redir_pc = 64'h300;
        push(64'h300, ADD, 1'b0);
        tick();
        redir = 1'b0;
        total++;
        if (state !== 2'd1 || dec.out_d_valid !== 1'b0 || imem_addr !== 64'h300) begin
            bad++;
            $display("FAIL ret_redirect: got state=%0d valid=%b addr=%h, required 1/0/300",
                     state, dec.out_d_valid, imem_addr);
        end
        tick();
        total++;
        if (dec.out_d_valid !== 1'b1 || dec.out_d_pc !== 64'h300) begin
            bad++;
            $display("FAIL ret_target: got valid=%b pc=%h, required 1/300", dec.out_d_valid, dec.out_d_pc);
        end
        tick();
        total++;
        if (state !== 2'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL ret_end: got state=%0d pending=%0d, required 3/0", state, sb.size());
        end
    endtask

    task automatic test_redirect_held();
        do_reset();
        dec.in_d_ready = 1'b0;
        mem[64] = ADD;
        mem[65] = ADD;
        mem[32] = ADD;
        entry_pc = 64'h100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        redir = 1'b1; redir_pc = 64'h80;
        push(64'h80, ADD, 1'b0);
        tick();
        redir = 1'b0;
        dec.in_d_ready = 1'b1;
        total++;
        if (dec.out_d_valid !== 1'b0 || count !== 32'd1) begin
            bad++;
            $display("FAIL redir_drop: got valid=%b count=%0d, required 0/1", dec.out_d_valid, count);
        end
        tick();
        total++;
        if (dec.out_d_valid !== 1'b1 || dec.out_d_pc !== 64'h80) begin
            bad++;
            $display("FAIL redir_target: got valid=%b pc=%h, required 1/80", dec.out_d_valid, dec.out_d_pc);
        end
        tick();
        total++;
        if (state !== 2'd3 || count !== 32'd2 || sb.size() != 0) begin
            bad++;
            $display("FAIL redir_end: got state=%0d count=%0d pending=%0d, required 3/2/0",
                     state, count, sb.size());
        end
    endtask

    task automatic test_fault();
        // misaligned entry, then redirect out of HALT with sticky fault
        do_reset();
        mem[64] = ADD;
        entry_pc = 64'h102; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (fault !== 1'b1 || state !== 2'd3 || dec.out_d_valid !== 1'b0 || count !== 32'd0) begin
            bad++;
            $display("FAIL fault_misalign: got fault=%b state=%0d valid=%b count=%0d, required 1/3/0/0",
                     fault, state, dec.out_d_valid, count);
        end
        redir = 1'b1; redir_pc = 64'h100;
        push(64'h100, ADD, 1'b0);
        tick();
        redir = 1'b0;
        tick(); tick();
        total++;
        if (fault !== 1'b1 || state !== 2'd3 || count !== 32'd1 || sb.size() != 0) begin
            bad++;
            $display("FAIL fault_sticky: got fault=%b state=%0d count=%0d pending=%0d, required 1/3/1/0",
                     fault, state, count, sb.size());
        end
        // last word of the page is legal; falling off the end faults
        do_reset();
        mem[1023] = ADD;
        push(64'hFFC, ADD, 1'b0);
        entry_pc = 64'hFFC; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (dec.out_d_valid !== 1'b1 || dec.out_d_pc !== 64'hFFC || fault !== 1'b0) begin
            bad++;
            $display("FAIL page_last: got valid=%b pc=%h fault=%b, required 1/ffc/0",
                     dec.out_d_valid, dec.out_d_pc, fault);
        end
        tick();
        total++;
        if (fault !== 1'b1 || state !== 2'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL page_end: got fault=%b state=%0d pending=%0d, required 1/3/0", fault, state, sb.size());
        end
        // zero word ends the program without a fault
        do_reset();
        entry_pc = 64'h10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (state !== 2'd3 || fault !== 1'b0 || dec.out_d_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_halt: got state=%0d fault=%b valid=%b, required 3/0/0",
                     state, fault, dec.out_d_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        dec.in_d_ready = 1'b0;
        mem[64] = ADD;
        entry_pc = 64'h100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (dec.out_d_valid !== 1'b1 || count !== 32'd1) begin
            bad++;
            $display("FAIL arst_pre: got valid=%b count=%0d, required 1/1", dec.out_d_valid, count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dec.out_d_valid !== 1'b0 || dec.out_d_pc !== 64'd0 || dec.out_d_insnbits !== 32'd0 ||
            dec.out_d_pred_taken !== 1'b0 || state !== 2'd0 || fault !== 1'b0 ||
            count !== 32'd0 || imem_addr !== 64'd0) begin
            bad++;
            $display("FAIL arst_clear: got valid=%b pc=%h insn=%h state=%0d fault=%b count=%0d addr=%h, required all 0",
                     dec.out_d_valid, dec.out_d_pc, dec.out_d_insnbits, state, fault, count, imem_addr);
        end
        dec.in_d_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sequential();
        test_branch();
        test_stall();
        test_ret();
        test_redirect_held();
        test_fault();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
